// File: rtl/lfsr_pkg.sv
// Shared constants and maximal-length tap table for the lfsr_gen family.
// A tap mask bit k set means state[k] feeds the XOR feedback into bit 0.
package lfsr_pkg;

    localparam int MIN_WIDTH = 3;
    localparam int MAX_WIDTH = 16;

    function automatic logic [MAX_WIDTH-1:0] tap_mask(input int w);
        logic [MAX_WIDTH-1:0] m;
        case (w)
            3:       m = 16'h0006;
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    function automatic int unsigned max_period(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational Fibonacci next-state: shift left, XOR of tapped bits enters at bit 0.
// Zero latency, no flow control.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    localparam logic [MAX_WIDTH-1:0] MASK_FULL = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0]     MASK      = MASK_FULL[WIDTH-1:0];

    assign next = {state[WIDTH-2:0], ^(state & MASK)};

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR random source with seed load, zero-lockup recovery and period monitor.
// One clock from enable/load to updated state; no backpressure, enable simply gates stepping.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter int          OUT_BITS = 4,
    parameter int unsigned SEED     = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed,
    output logic [WIDTH-1:0]    state,
    output logic [OUT_BITS-1:0] randomNumber,
    output logic                period_done,
    output logic [WIDTH-1:0]    period_len,
    output logic                lockup
);

    localparam logic [WIDTH-1:0] SEED_V = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be within 3..16");
    end
    if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
        $error("lfsr_gen: OUT_BITS must be within 1..WIDTH");
    end
    if (SEED_V == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero");
    end

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] anchor;
    logic [WIDTH-1:0] step_cnt;

    lfsr_next #(.WIDTH(WIDTH)) u_next (
        .state (state),
        .next  (nxt)
    );

    assign randomNumber = state[OUT_BITS-1:0];

    // anchor is the value whose recurrence closes a period; it follows every (re)seed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= SEED_V;
            anchor      <= SEED_V;
            step_cnt    <= '0;
            period_len  <= '0;
            period_done <= 1'b0;
            lockup      <= 1'b0;
        end else begin
            period_done <= 1'b0;
            lockup      <= 1'b0;
            if (load) begin
                step_cnt <= '0;
                if (seed != '0) begin
                    state  <= seed;
                    anchor <= seed;
                end else begin
                    state  <= SEED_V;
                    anchor <= SEED_V;
                    lockup <= 1'b1;
                end
            end else if (state == '0) begin
                state    <= SEED_V;
                anchor   <= SEED_V;
                step_cnt <= '0;
                lockup   <= 1'b1;
            end else if (enable) begin
                state <= nxt;
                if (nxt == anchor) begin
                    period_done <= 1'b1;
                    period_len  <= step_cnt + ONE;
                    step_cnt    <= '0;
                end else begin
                    step_cnt <= step_cnt + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench: 4-bit table-driven sequence checks plus an 8-bit full-period run.
module tb_lfsr_gen;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [3:0] seed = 4'h0;
    logic [3:0] state;
    logic [3:0] rnd;
    logic       pd;
    logic [3:0] plen;
    logic       lk;

    logic       enable8 = 1'b0;
    logic [7:0] state8;
    logic [2:0] rnd8;
    logic       pd8;
    logic [7:0] plen8;
    logic       lk8;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    lfsr_gen #(.WIDTH(4), .OUT_BITS(4), .SEED(1)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .load         (load),
        .seed         (seed),
        .state        (state),
        .randomNumber (rnd),
        .period_done  (pd),
        .period_len   (plen),
        .lockup       (lk)
    );

    lfsr_gen #(.WIDTH(8), .OUT_BITS(3), .SEED(1)) dut8 (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable8),
        .load         (1'b0),
        .seed         (8'h00),
        .state        (state8),
        .randomNumber (rnd8),
        .period_done  (pd8),
        .period_len   (plen8),
        .lockup       (lk8)
    );

    typedef struct {
        logic       ld;
        logic       en;
        logic [3:0] sd;
        logic [3:0] st;
        logic       pd;
        logic       lk;
        logic [3:0] pl;
    } vec_t;

    vec_t vecs[$];

    // Hand-derived x^4+x^3+1 sequence following 0001.
    logic [3:0] seq4 [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                              4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    int         p;
    logic [3:0] plen_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic l, input logic e, input logic [3:0] s,
                       input logic [3:0] st, input logic pdx, input logic lkx);
        vec_t v;
        v.ld = l; v.en = e; v.sd = s; v.st = st; v.pd = pdx; v.lk = lkx; v.pl = plen_e;
        vecs.push_back(v);
    endtask

    task automatic run(input int n, input int pd_step);
        for (int i = 1; i <= n; i++) begin
            p = (p + 1) % 15;
            if (i == pd_step) plen_e = 4'd15;
            add(1'b0, 1'b1, 4'h0, seq4[p], i == pd_step, 1'b0);
        end
    endtask

    function automatic logic [7:0] ref8(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] model;

        // Build vector table.
        p = 14;
        plen_e = 4'd0;
        run(15, 15);
        run(15, 15);
        add(1'b1, 1'b1, 4'hB, 4'hB, 1'b0, 1'b0);
        p = 8;
        run(15, 15);
        run(4, 0);
        add(1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 1'b1);
        p = 14;
        add(1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0);
        run(15, 15);
        run(6, 0);
        for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 4'h0, seq4[p], 1'b0, 1'b0);
        run(1, 0);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #3 reset = 1'b1;
        #1;
        chk("rst_state", state, 4'h1);
        chk("rst_rnd", rnd, 4'h1);
        chk("rst_pd", pd, 1'b0);
        chk("rst_lk", lk, 1'b0);
        chk("rst_plen", plen, 4'h0);
        chk("rst_state8", state8, 8'h01);
        #14 reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clock);
            load = vecs[i].ld;
            enable = vecs[i].en;
            seed = vecs[i].sd;
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_state", i), state, vecs[i].st);
            chk($sformatf("v%0d_rnd", i), rnd, vecs[i].st);
            chk($sformatf("v%0d_pd", i), pd, vecs[i].pd);
            chk($sformatf("v%0d_lk", i), lk, vecs[i].lk);
            chk($sformatf("v%0d_plen", i), plen, vecs[i].pl);
        end
        @(negedge clock);
        load = 1'b0;
        enable = 1'b0;
        seed = 4'h0;

        // Reset while running with nonzero period_len: must clear without a clock edge.
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_state", state, 4'h1);
        chk("mid_rst_plen", plen, 4'h0);
        chk("mid_rst_pd", pd, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        enable = 1'b1;
        @(posedge clock);
        #1;
        chk("post_rst_state", state, 4'h2);
        chk("post_rst_plen", plen, 4'h0);
        @(negedge clock);
        enable = 1'b0;

        // 8-bit full period from SEED.
        enable8 = 1'b1;
        model = 8'h01;
        for (int i = 1; i <= 255; i++) begin
            @(posedge clock);
            #1;
            model = ref8(model);
            chk($sformatf("w8_s%0d_state", i), state8, model);
            chk($sformatf("w8_s%0d_rnd", i), rnd8, model[2:0]);
            chk($sformatf("w8_s%0d_nonzero", i), state8 != 8'h00, 1'b1);
            chk($sformatf("w8_s%0d_pd", i), pd8, i == 255);
            chk($sformatf("w8_s%0d_lk", i), lk8, 1'b0);
        end
        chk("w8_plen", plen8, 8'd255);
        chk("w8_back_to_seed", state8, 8'h01);
        @(negedge clock);
        enable8 = 1'b0;
        @(posedge clock);
        #1;
        chk("w8_pd_clear", pd8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
